// File: rtl/icache_if.sv
// icache bus bundle: Fetcher lookup side and memory controller side.
// slave is the cache's view; master is the Fetcher/controller view.
interface icache_if #(
  parameter int XLEN = 32
);
  logic            fet_req;
  logic [XLEN-1:0] fet_pc;
  logic            ic_hit;
  logic [XLEN-1:0] ic_inst;
  logic            ic_mem_enable;
  logic [XLEN-1:0] ic_mem_pc;
  logic            mem_fet_busy;
  logic            mem_inst_ready;
  logic [XLEN-1:0] mem_inst;
  logic [XLEN-1:0] mem_inst_addr;

  modport slave (
    input  fet_req, fet_pc,
    input  mem_fet_busy, mem_inst_ready,
    input  mem_inst, mem_inst_addr,
    output ic_hit, ic_inst,
    output ic_mem_enable, ic_mem_pc
  );

  modport master (
    output fet_req, fet_pc,
    output mem_fet_busy, mem_inst_ready,
    output mem_inst, mem_inst_addr,
    input  ic_hit, ic_inst,
    input  ic_mem_enable, ic_mem_pc
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one instruction per line.
// Combinational hits, single-request miss handling with fill bypass.
module icache #(
  parameter int XLEN        = 32,
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = XLEN - INDEX_WIDTH - 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    flush,
  input  logic    ic_inv,
  icache_if.slave bus
);

  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state_q, state_d;
  logic [XLEN-1:0] miss_pc_q, miss_pc_d;

  logic [LINES-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q  [LINES];
  logic [XLEN-1:0]      data_q [LINES];

  logic [INDEX_WIDTH-1:0] fet_idx;
  logic [TAG_WIDTH-1:0]   fet_tag;
  logic [INDEX_WIDTH-1:0] miss_idx;
  logic [TAG_WIDTH-1:0]   miss_tag;

  logic lookup_hit;
  logic fill_accept;
  logic fill_bypass;
  logic mem_en;

  assign fet_idx  = bus.fet_pc[INDEX_WIDTH:1];
  assign fet_tag  = bus.fet_pc[XLEN-1:INDEX_WIDTH+1];
  assign miss_idx = miss_pc_q[INDEX_WIDTH:1];
  assign miss_tag = miss_pc_q[XLEN-1:INDEX_WIDTH+1];

  assign lookup_hit = bus.fet_req
                   && valid_q[fet_idx]
                   && (tag_q[fet_idx] == fet_tag);

  // A fill only lands when the pipeline is enabled, so the
  // bypass hit and the array write always happen together.
  assign fill_accept = rdy
                    && (state_q == WAIT)
                    && bus.mem_inst_ready
                    && (bus.mem_inst_addr == miss_pc_q)
                    && !flush;

  assign fill_bypass = fill_accept
                    && bus.fet_req
                    && (bus.fet_pc == miss_pc_q);

  // Gated by rdy so a stalled pipeline never repeats the request.
  assign mem_en = rdy
               && (state_q == REQ)
               && !bus.mem_fet_busy
               && !flush;

  assign bus.ic_hit        = lookup_hit || fill_bypass;
  assign bus.ic_mem_enable = mem_en;
  assign bus.ic_mem_pc     = (state_q == IDLE) ? '0 : miss_pc_q;

  // Instruction output: returned word on bypass, else line data.
  always_comb begin
    bus.ic_inst = '0;
    if (fill_bypass)
      bus.ic_inst = bus.mem_inst;
    else if (lookup_hit)
      bus.ic_inst = data_q[fet_idx];
  end

  // Miss FSM next-state; flush overrides any progress.
  always_comb begin
    state_d   = state_q;
    miss_pc_d = miss_pc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.fet_req && !lookup_hit && !flush) begin
          state_d   = REQ;
          miss_pc_d = bus.fet_pc;
        end
      end
      REQ: begin
        if (mem_en)
          state_d = WAIT;
      end
      WAIT: begin
        if (fill_accept)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush)
      state_d = IDLE;
  end

  // FSM registers and valid bits; a fill beats a same-cycle inv.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      miss_pc_q <= '0;
      valid_q   <= '0;
    end else if (rdy) begin
      state_q   <= state_d;
      miss_pc_q <= miss_pc_d;
      if (ic_inv)
        valid_q <= '0;
      if (fill_accept)
        valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays, written only on an accepted fill.
  always_ff @(posedge clk) begin
    if (fill_accept) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= bus.mem_inst;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected hits and
// memory requests; a negedge monitor pops and compares them.
module tb_icache;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;
  logic ic_inv;

  icache_if #(.XLEN(32)) bus ();

  icache dut (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .flush  (flush),
    .ic_inv (ic_inv),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] hit_q [$];
  logic [31:0] req_q [$];
  logic        exp_miss = 1'b0;
  logic        mon_en   = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every hit and every request must match the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.ic_hit) begin
        if (hit_q.size() == 0)
          chk("unexpected_hit", bus.ic_inst, 32'hxxxx_xxxx);
        else
          chk("hit_inst", bus.ic_inst, hit_q.pop_front());
      end
      if (bus.ic_mem_enable) begin
        if (req_q.size() == 0)
          chk("unexpected_req", bus.ic_mem_pc, 32'hxxxx_xxxx);
        else
          chk("req_pc", bus.ic_mem_pc, req_q.pop_front());
      end
      if (exp_miss && bus.fet_req)
        chk("miss_no_hit", {31'd0, bus.ic_hit}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.fet_req        = 1'b0;
    bus.mem_inst_ready = 1'b0;
    exp_miss           = 1'b0;
  endtask

  // Miss in IDLE, one request, lat WAIT cycles, bypassed fill.
  task automatic miss_fill(logic [31:0] pc, logic [31:0] d,
                           int lat, logic inv_at_fill);
    bus.fet_req = 1'b1;
    bus.fet_pc  = pc;
    exp_miss    = 1'b1;
    req_q.push_back(pc);
    step();
    idle_in();
    step();
    repeat (lat) step();
    bus.mem_inst_ready = 1'b1;
    bus.mem_inst_addr  = pc;
    bus.mem_inst       = d;
    bus.fet_req        = 1'b1;
    bus.fet_pc         = pc;
    ic_inv             = inv_at_fill;
    hit_q.push_back(d);
    step();
    ic_inv = 1'b0;
    idle_in();
  endtask

  task automatic lookup_hit(logic [31:0] pc, logic [31:0] d);
    bus.fet_req = 1'b1;
    bus.fet_pc  = pc;
    hit_q.push_back(d);
    step();
    idle_in();
  endtask

  // Miss lookup; the started miss is then flushed in REQ.
  task automatic lookup_miss(logic [31:0] pc);
    bus.fet_req = 1'b1;
    bus.fet_pc  = pc;
    exp_miss    = 1'b1;
    step();
    idle_in();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] fills [4];
    fills[0] = 32'h0000_0010;
    fills[1] = 32'h0000_0020;
    fills[2] = 32'h0000_0030;
    fills[3] = 32'h0000_0040;

    rst                = 1'b1;
    rdy                = 1'b1;
    flush              = 1'b0;
    ic_inv             = 1'b0;
    bus.fet_req        = 1'b0;
    bus.fet_pc         = '0;
    bus.mem_fet_busy   = 1'b0;
    bus.mem_inst_ready = 1'b0;
    bus.mem_inst       = '0;
    bus.mem_inst_addr  = '0;

    @(posedge clk);
    @(negedge clk);
    chk("rst_hit", {31'd0, bus.ic_hit}, 32'd0);
    chk("rst_inst", bus.ic_inst, 32'd0);
    chk("rst_en", {31'd0, bus.ic_mem_enable}, 32'd0);
    chk("rst_mem_pc", bus.ic_mem_pc, 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Cold miss then zero-latency hit.
    miss_fill(32'h0000_0100, 32'h0000_0513, 2, 1'b0);
    lookup_hit(32'h0000_0100, 32'h0000_0513);

    // Conflict eviction at index 0.
    miss_fill(32'h0000_0180, 32'hABCD_0000, 1, 1'b0);
    lookup_miss(32'h0000_0100);
    lookup_hit(32'h0000_0180, 32'hABCD_0000);

    // Busy backpressure: enable held off for 5 cycles.
    bus.mem_fet_busy = 1'b1;
    bus.fet_req      = 1'b1;
    bus.fet_pc       = 32'h0000_0500;
    exp_miss         = 1'b1;
    step();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_mem_pc", bus.ic_mem_pc, 32'h0000_0500);
      step();
    end
    bus.mem_fet_busy = 1'b0;
    req_q.push_back(32'h0000_0500);
    step();
    step();
    bus.mem_inst_ready = 1'b1;
    bus.mem_inst_addr  = 32'h0000_0500;
    bus.mem_inst       = 32'h0000_0093;
    step();
    idle_in();
    lookup_hit(32'h0000_0500, 32'h0000_0093);

    // Flush while waiting; stale return must not fill.
    bus.fet_req = 1'b1;
    bus.fet_pc  = 32'h0000_0200;
    exp_miss    = 1'b1;
    req_q.push_back(32'h0000_0200);
    step();
    idle_in();
    step();
    flush = 1'b1;
    step();
    flush              = 1'b0;
    bus.mem_inst_ready = 1'b1;
    bus.mem_inst_addr  = 32'h0000_0200;
    bus.mem_inst       = 32'hDEAD_BEEF;
    step();
    idle_in();
    miss_fill(32'h0000_0200, 32'h0000_0297, 0, 1'b0);

    // Wrong-address ready ignored; held ready fills once.
    bus.fet_req = 1'b1;
    bus.fet_pc  = 32'h0000_0300;
    exp_miss    = 1'b1;
    req_q.push_back(32'h0000_0300);
    step();
    idle_in();
    step();
    bus.mem_inst_ready = 1'b1;
    bus.mem_inst_addr  = 32'h0000_0304;
    bus.mem_inst       = 32'h0000_1111;
    bus.fet_req        = 1'b1;
    bus.fet_pc         = 32'h0000_0300;
    exp_miss           = 1'b1;
    step();
    exp_miss          = 1'b0;
    bus.mem_inst_addr = 32'h0000_0300;
    bus.mem_inst      = 32'h0000_2222;
    for (int i = 0; i < 3; i++) begin
      hit_q.push_back(32'h0000_2222);
      step();
    end
    idle_in();
    @(negedge clk);
    chk("held_ready_idle", bus.ic_mem_pc, 32'd0);
    step();

    // Invalidate all, then inv coinciding with a fill.
    for (int i = 0; i < 4; i++)
      miss_fill(fills[i], 32'h1000_0000 + i, 0, 1'b0);
    lookup_hit(fills[2], 32'h1000_0002);
    ic_inv = 1'b1;
    step();
    ic_inv = 1'b0;
    for (int i = 0; i < 4; i++)
      lookup_miss(fills[i]);
    lookup_miss(32'h0000_0300);
    miss_fill(32'h0000_0400, 32'h0000_4567, 1, 1'b1);
    lookup_hit(32'h0000_0400, 32'h0000_4567);

    repeat (3) step();
    chk("hit_q_empty", hit_q.size(), 32'd0);
    chk("req_q_empty", req_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
